// File: rtl/scan_pkg.sv
// Shared definitions for the scan controller.
//   state_e      : FSM state encoding, also driven on state_o
//   SPD_W        : width of the speed level
//   TICK_W       : width of the step period / tick counter
//   step_period(): cycles per step for a given clock frequency and speed level
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HOME  = 2'd3
  } state_e;

  localparam int unsigned SPD_W  = 2;
  localparam int unsigned TICK_W = 25;
  localparam logic [SPD_W-1:0] SPD_MAX = '1;

  // Each speed level halves the step period: clk_freq / (100 << spd).
  function automatic logic [TICK_W-1:0] step_period(input int unsigned clk_freq,
                                                    input logic [SPD_W-1:0] spd);
    int unsigned div;
    div = 32'd100 << spd;
    return TICK_W'(clk_freq / div);
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Programmable period counter for the scan step rate.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clr_i    : restart the count from 0 (wins over hold)
//   hold_i   : freeze the count, suppress tick
//   period_i : cycles per tick
//   tick_o   : one-cycle pulse in the cycle the count sits at period_i-1
module step_tick_gen
  import scan_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              hold_i,
  input  logic [TICK_W-1:0] period_i,
  output logic              tick_o
);

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              at_end;

  // >= so a count left beyond a shorter period still wraps cleanly.
  assign at_end = (cnt_q >= period_i - TICK_W'(1));
  assign tick_o = at_end && !hold_i && !clr_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      cnt_d = at_end ? '0 : cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scan_ctrl.sv
// Scan controller: start/pause/stop keys drive a forward scan from 0 to
// POS_MAX, then an automatic homing pass back to 0 at the fastest rate.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_cap, stop_cap   : one-cycle key presses (start/pause/resume, abort)
//   spd_up_cap, spd_dn_cap: one-cycle key presses for speed level 0..3
//   step_o                : one-cycle step pulse, pos_o already updated
//   dir_o                 : 1 forward, 0 homing
//   pos_o, speed_o        : current position and speed level
//   state_o, busy_o       : FSM state, high when not idle
//   done_o                : pulse with the step that reaches POS_MAX
//
// state | meaning
// IDLE  | waiting for start, position at 0
// RUN   | stepping forward at the selected speed
// PAUSE | forward scan frozen, tick count held
// HOME  | stepping back to 0 at top speed, keys ignored
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned POS_W    = 8,
  parameter int unsigned POS_MAX  = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_cap,
  input  logic             stop_cap,
  input  logic             spd_up_cap,
  input  logic             spd_dn_cap,
  output logic             step_o,
  output logic             dir_o,
  output logic [POS_W-1:0] pos_o,
  output logic [1:0]       speed_o,
  output logic [1:0]       state_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX);

  state_e            state_q, state_d;
  logic [SPD_W-1:0]  spd_q, spd_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              step_q, step_d;
  logic              done_q, done_d;
  logic [TICK_W-1:0] period;
  logic              tick, tick_clr, tick_hold;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; stop outranks start wherever stop is honoured.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_cap) state_d = ST_RUN;
      ST_RUN: begin
        if (pos_q == POS_LAST) state_d = ST_HOME;
        else if (stop_cap)     state_d = ST_HOME;
        else if (start_cap)    state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop_cap)       state_d = ST_HOME;
        else if (start_cap) state_d = ST_RUN;
      end
      ST_HOME:  if (pos_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    state_o = state_q;
    busy_o  = (state_q != ST_IDLE);
    dir_o   = (state_q != ST_HOME);
  end

  // Speed level, saturating; simultaneous up+down cancel.
  always_comb begin
    spd_d = spd_q;
    if (spd_up_cap && !spd_dn_cap && spd_q != SPD_MAX)   spd_d = spd_q + SPD_W'(1);
    else if (spd_dn_cap && !spd_up_cap && spd_q != '0)   spd_d = spd_q - SPD_W'(1);
  end

  // Period restarts on a fresh scan, on entering HOME and on a speed change.
  assign period    = (state_q == ST_HOME) ? step_period(CLK_FREQ, SPD_MAX)
                                          : step_period(CLK_FREQ, spd_q);
  assign tick_clr  = (state_q == ST_IDLE && state_d == ST_RUN) ||
                     (state_q != ST_HOME && state_d == ST_HOME) ||
                     (spd_d != spd_q);
  assign tick_hold = !(state_q == ST_RUN || state_q == ST_HOME);

  step_tick_gen u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tick_clr),
    .hold_i   (tick_hold),
    .period_i (period),
    .tick_o   (tick)
  );

  // Position and step pulse are registered together so pos_o is already
  // updated in the cycle step_o is high.
  always_comb begin
    pos_d  = pos_q;
    step_d = 1'b0;
    done_d = 1'b0;
    if (state_q == ST_IDLE && state_d == ST_RUN) begin
      pos_d = '0;
    end else if (tick) begin
      if (state_q == ST_RUN && pos_q < POS_LAST) begin
        pos_d  = pos_q + POS_W'(1);
        step_d = 1'b1;
        done_d = ((pos_q + POS_W'(1)) == POS_LAST);
      end else if (state_q == ST_HOME && pos_q != '0) begin
        pos_d  = pos_q - POS_W'(1);
        step_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spd_q  <= '0;
      pos_q  <= '0;
      step_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      spd_q  <= spd_d;
      pos_q  <= pos_d;
      step_q <= step_d;
      done_q <= done_d;
    end
  end

  assign pos_o   = pos_q;
  assign speed_o = spd_q;
  assign step_o  = step_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_scan_ctrl.sv
module tb_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_cap = 1'b0, stop_cap = 1'b0, spd_up_cap = 1'b0, spd_dn_cap = 1'b0;
  logic       step_o, dir_o, busy_o, done_o;
  logic [7:0] pos_o;
  logic [1:0] speed_o, state_o;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  pos;
    logic        dir;
    logic        done;
  } exp_t;
  exp_t sb[$];

  scan_ctrl #(.CLK_FREQ(8000), .POS_W(8), .POS_MAX(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_cap  (start_cap),
    .stop_cap   (stop_cap),
    .spd_up_cap (spd_up_cap),
    .spd_dn_cap (spd_dn_cap),
    .step_o     (step_o),
    .dir_o      (dir_o),
    .pos_o      (pos_o),
    .speed_o    (speed_o),
    .state_o    (state_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int unsigned c, input logic [7:0] p, input logic d, input logic dn);
    exp_t e;
    e.cyc = c; e.pos = p; e.dir = d; e.done = dn;
    sb.push_back(e);
  endtask

  // Every step_o is matched against the oldest expected step.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (step_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step cyc=%0d pos=%0d", cyc, pos_o);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || pos_o !== e.pos || dir_o !== e.dir || done_o !== e.done) begin
            errors++;
            $display("FAIL step got cyc=%0d pos=%0d dir=%0d done=%0d exp cyc=%0d pos=%0d dir=%0d done=%0d",
                     cyc, pos_o, dir_o, done_o, e.cyc, e.pos, e.dir, e.done);
          end
        end
      end else if (done_o) begin
        checks++;
        errors++;
        $display("FAIL done_without_step cyc=%0d", cyc);
      end
    end
  endtask

  // k: 0 start, 1 stop, 2 up, 3 down, 4 start+stop, 5 up+down
  task automatic press(input int k);
    start_cap  = (k == 0 || k == 4);
    stop_cap   = (k == 1 || k == 4);
    spd_up_cap = (k == 2 || k == 5);
    spd_dn_cap = (k == 3 || k == 5);
    @(negedge clk);
    start_cap = 1'b0; stop_cap = 1'b0; spd_up_cap = 1'b0; spd_dn_cap = 1'b0;
  endtask

  task automatic go_to(input int unsigned target);
    checks++;
    if (cyc > target) begin
      errors++;
      $display("FAIL go_to_late got %0d exp %0d", cyc, target);
    end
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int unsigned exp_cyc, input string name);
    int n = 0;
    while (state_o != 2'd0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state_o !== 2'd0 || cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s_idle got state=%0d cyc=%0d exp state=0 cyc=%0d", name, state_o, cyc, exp_cyc);
    end
  endtask

  task automatic check_state(input logic [1:0] exp, input string name);
    checks++;
    if (state_o !== exp) begin
      errors++;
      $display("FAIL %s_state got %0d exp %0d", name, state_o, exp);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_steps got %0d pending exp 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state_o !== 2'd0 || pos_o !== 8'd0 || speed_o !== 2'd0 || dir_o !== 1'b1 ||
        step_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset got st=%0d pos=%0d spd=%0d dir=%0d step=%0d done=%0d busy=%0d exp 0 0 0 1 0 0 0",
               state_o, pos_o, speed_o, dir_o, step_o, done_o, busy_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_scan();
    int unsigned r, h;
    r = cyc + 1;
    h = r + 241;
    push(r + 80, 8'd1, 1'b1, 1'b0);
    push(r + 160, 8'd2, 1'b1, 1'b0);
    push(r + 240, 8'd3, 1'b1, 1'b1);
    push(h + 10, 8'd2, 1'b0, 1'b0);
    push(h + 20, 8'd1, 1'b0, 1'b0);
    push(h + 30, 8'd0, 1'b0, 1'b0);
    press(0);
    checks++;
    if (state_o !== 2'd1 || pos_o !== 8'd0 || dir_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL scan_entry got st=%0d pos=%0d dir=%0d busy=%0d exp 1 0 1 1", state_o, pos_o, dir_o, busy_o);
    end
    go_to(h);
    check_state(2'd3, "scan_home");
    wait_idle(h + 31, "scan");
    check_sb_empty("scan");
  endtask

  task automatic test_pause();
    int unsigned r, s;
    r = cyc + 1;
    press(0);
    go_to(r + 29);
    press(0);
    check_state(2'd2, "pause");
    go_to(r + 129);
    check_state(2'd2, "pause_hold");
    s = r + 130;
    push(s + 50, 8'd1, 1'b1, 1'b0);
    push(s + 130, 8'd2, 1'b1, 1'b0);
    push(s + 210, 8'd3, 1'b1, 1'b1);
    push(s + 221, 8'd2, 1'b0, 1'b0);
    push(s + 231, 8'd1, 1'b0, 1'b0);
    push(s + 241, 8'd0, 1'b0, 1'b0);
    press(0);
    check_state(2'd1, "resume");
    wait_idle(s + 242, "pause");
    check_sb_empty("pause");
  endtask

  task automatic test_both_keys();
    int unsigned r, h;
    r = cyc + 1;
    push(r + 80, 8'd1, 1'b1, 1'b0);
    push(r + 160, 8'd2, 1'b1, 1'b0);
    press(4);
    check_state(2'd1, "both_idle");
    go_to(r + 160);
    h = r + 161;
    push(h + 10, 8'd1, 1'b0, 1'b0);
    push(h + 20, 8'd0, 1'b0, 1'b0);
    press(4);
    check_state(2'd3, "both_run");
    wait_idle(h + 21, "both");
    check_sb_empty("both");
  endtask

  task automatic test_speed();
    logic [1:0] exp_up[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] exp_dn[4] = '{2'd2, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      press(2);
      checks++;
      if (speed_o !== exp_up[i]) begin
        errors++;
        $display("FAIL speed_up%0d got %0d exp %0d", i, speed_o, exp_up[i]);
      end
    end
    press(5);
    checks++;
    if (speed_o !== 2'd3) begin
      errors++;
      $display("FAIL speed_both got %0d exp 3", speed_o);
    end
    for (int i = 0; i < 4; i++) begin
      press(3);
      checks++;
      if (speed_o !== exp_dn[i]) begin
        errors++;
        $display("FAIL speed_dn%0d got %0d exp %0d", i, speed_o, exp_dn[i]);
      end
    end
  endtask

  task automatic test_fast_scan();
    int unsigned r, h;
    press(2);
    press(2);
    r = cyc + 1;
    h = r + 61;
    push(r + 20, 8'd1, 1'b1, 1'b0);
    push(r + 40, 8'd2, 1'b1, 1'b0);
    push(r + 60, 8'd3, 1'b1, 1'b1);
    push(h + 10, 8'd2, 1'b0, 1'b0);
    push(h + 20, 8'd1, 1'b0, 1'b0);
    push(h + 30, 8'd0, 1'b0, 1'b0);
    press(0);
    wait_idle(h + 31, "fast");
    check_sb_empty("fast");
    press(3);
    press(3);
  endtask

  task automatic test_reset_in_run();
    int unsigned r;
    press(2);
    r = cyc + 1;
    push(r + 40, 8'd1, 1'b1, 1'b0);
    push(r + 80, 8'd2, 1'b1, 1'b0);
    press(0);
    go_to(r + 80);
    rst_i = 1'b1;
    start_cap = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    start_cap = 1'b0;
    checks++;
    if (state_o !== 2'd0 || pos_o !== 8'd0 || speed_o !== 2'd0 || busy_o !== 1'b0 ||
        step_o !== 1'b0 || dir_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_run got st=%0d pos=%0d spd=%0d busy=%0d step=%0d dir=%0d exp 0 0 0 0 0 1",
               state_o, pos_o, speed_o, busy_o, step_o, dir_o);
    end
    repeat (100) @(negedge clk);
    check_state(2'd0, "rst_key_dropped");
    check_sb_empty("rst_run");
  endtask

  task automatic test_early_stop();
    int unsigned r;
    r = cyc + 1;
    press(0);
    go_to(r + 10);
    press(1);
    checks++;
    if (state_o !== 2'd3 || dir_o !== 1'b0) begin
      errors++;
      $display("FAIL early_home got st=%0d dir=%0d exp 3 0", state_o, dir_o);
    end
    @(negedge clk);
    checks++;
    if (state_o !== 2'd0 || busy_o !== 1'b0 || pos_o !== 8'd0) begin
      errors++;
      $display("FAIL early_idle got st=%0d busy=%0d pos=%0d exp 0 0 0", state_o, busy_o, pos_o);
    end
    repeat (100) @(negedge clk);
    check_sb_empty("early");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_full_scan();
    test_pause();
    test_both_keys();
    test_speed();
    test_fast_scan();
    test_reset_in_run();
    test_early_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter CLK_FREQ, 100000000, clock frequency in Hz.
REQ-002 Parameter POS_W, 8, position counter width.
REQ-003 Parameter POS_MAX, 255, last scan position, range 1..2^POS_W-1.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 start_cap  in  1  one-cycle debounced press: start, pause or resume.
REQ-007 stop_cap  in  1  one-cycle debounced press: abort scan.
REQ-008 spd_up_cap  in  1  one-cycle debounced press: faster.
REQ-009 spd_dn_cap  in  1  one-cycle debounced press: slower.
REQ-010 step_o  out  1  one-cycle step pulse to the scan datapath.
REQ-011 dir_o  out  1  1 = forward (increment), 0 = homing (decrement).
REQ-012 pos_o  out  POS_W  current position.
REQ-013 speed_o  out  2  speed level 0..3.
REQ-014 state_o  out  2  FSM state encoding.
REQ-015 busy_o  out  1  high whenever state is not IDLE.
REQ-016 done_o  out  1  one-cycle pulse when a forward scan reaches POS_MAX.

Function
REQ-017 States SHALL be IDLE=0, RUN=1, PAUSE=2 and HOME=3; state_o SHALL show the current state.
REQ-018 Step period P(s) SHALL be CLK_FREQ/(100<<s) cycles, with integer division, for speed level s; HOME SHALL always use P(3).
REQ-019 The tick counter SHALL count 0..P-1 while in RUN or HOME, hold while in PAUSE, and clear on entry to RUN from IDLE, on entry to HOME, and on any change of speed level.
REQ-020 step_o SHALL assert for 1 cycle when the tick counter reaches P-1; pos_o SHALL show the updated value in that same cycle; the first step SHALL come exactly P cycles after state becomes RUN or HOME.
REQ-021 IDLE: start_cap SHALL move to RUN next cycle with pos_o=0 and dir_o=1; stop_cap SHALL be ignored.
REQ-022 RUN: each step SHALL increment pos_o; the step that makes pos_o equal POS_MAX SHALL also pulse done_o and move to HOME next cycle.
REQ-023 RUN: start_cap SHALL move to PAUSE; stop_cap SHALL move to HOME.
REQ-024 PAUSE: start_cap SHALL resume RUN with the held tick count; stop_cap SHALL move to HOME.
REQ-025 HOME: dir_o SHALL be 0 and each step SHALL decrement pos_o; when pos_o reaches 0 the state SHALL go to IDLE next cycle; if HOME is entered with pos_o=0, the state SHALL go to IDLE next cycle with no step; all key inputs SHALL be ignored.
REQ-026 If start_cap and stop_cap are both high, stop SHALL take priority.
REQ-027 spd_up_cap SHALL increment speed_o and spd_dn_cap SHALL decrement it, saturating at 3 and 0; if both are high together, speed_o SHALL not change; speed keys SHALL be accepted in every state.
REQ-028 pos_o SHALL never wrap: it SHALL never exceed POS_MAX and never go below 0.

Reset
REQ-029 rst_i high SHALL, at the next edge, force state=IDLE, pos_o=0, speed_o=0, dir_o=1, step_o=0, done_o=0, busy_o=0, and tick counter=0, including when a scan is in progress.
REQ-030 Key pulses present in the reset cycle SHALL be discarded.

Structure
REQ-031 Package scan_pkg SHALL hold the state encodings, the speed-level width and the period function P(s).
REQ-032 Sub-module step_tick_gen SHALL hold the programmable period counter, with inputs clr, hold and period and a one-cycle tick output; the FSM and position logic SHALL stay in scan_ctrl.
REQ-033 The tick counter SHALL be 25 bits wide.

Verification (CLK_FREQ=8000, POS_MAX=3, so P = 80/40/20/10)
REQ-034 Start at speed 0 -> step_o at 80, 160 and 240 cycles after RUN entry; pos_o 1, 2, 3; done_o with the third step; HOME; steps every 10 cycles; pos_o 2, 1, 0; then IDLE.
REQ-035 Start, then start at cycle 30 of RUN, wait 100 cycles, then start again -> no steps during PAUSE; first step 50 cycles after resume.
REQ-036 Start and stop_cap in the same cycle while IDLE -> RUN; start and stop_cap together in RUN at pos_o=2 -> HOME, two steps down, IDLE.
REQ-037 spd_up_cap ×5 -> speed_o=3; spd_up_cap and spd_dn_cap together -> speed_o stays 3; spd_dn_cap ×4 -> speed_o=0.
REQ-038 rst_i in RUN at pos_o=2 -> next cycle IDLE, pos_o=0, speed_o=0, busy_o=0, no step_o.
REQ-039 stop_cap in RUN before the first step -> HOME, then IDLE next cycle, with no step_o.
